// File: rtl/note_pkg.sv
// Shared types and constants for the note key encoder.
// Octave states, note codes and the default debounce length.
package note_pkg;

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        MID  = 2'd1,
        HIGH = 2'd2
    } octave_t;

    localparam logic [2:0] NOTE_NONE = 3'd0;
    localparam logic [2:0] NOTE_C    = 3'd1;
    localparam logic [2:0] NOTE_D    = 3'd2;
    localparam logic [2:0] NOTE_E    = 3'd3;
    localparam logic [2:0] NOTE_F    = 3'd4;
    localparam logic [2:0] NOTE_G    = 3'd5;
    localparam logic [2:0] NOTE_A    = 3'd6;
    localparam logic [2:0] NOTE_B    = 3'd7;

    localparam int DEBOUNCE_DEFAULT = 16;

    // Bit 0 is c, bit 6 is b.
    function automatic logic [6:0] code_onehot(input logic [2:0] code);
        if (code == NOTE_NONE)
            code_onehot = 7'd0;
        else
            code_onehot = 7'd1 << (code - 3'd1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce counter.
// The debounced level flips only after DEBOUNCE_CYCLES disagreeing samples.
module key_debounce
    import note_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        s1;
    logic        s2;
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= 16'd0;
            db  <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == db) begin
                cnt <= 16'd0;
            end else if (cnt == LAST) begin
                db  <= ~db;
                cnt <= 16'd0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/note_key_encoder.sv
// Debounced note keys to one-hot note plus three-state octave FSM.
// Define NOTE_KEY_HOLD_EN to hold the last note after all keys release.
module note_key_encoder
    import note_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_c,
    input  logic       key_d,
    input  logic       key_e,
    input  logic       key_f,
    input  logic       key_g,
    input  logic       key_a,
    input  logic       key_b,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       a,
    output logic       b,
    output logic       up,
    output logic       down,
    output logic       note_valid,
    output logic [2:0] note_code
);

    logic [8:0] raw;
    logic [8:0] db;
    logic [1:0] btn_q;
    logic       up_e;
    logic       dn_e;
    octave_t    oct;
    logic [2:0] code_nxt;
    logic [2:0] code_q;
    logic [6:0] onehot_q;

    assign raw = {btn_down, btn_up, key_b, key_a,
                  key_g, key_f, key_e, key_d, key_c};

    for (genvar i = 0; i < 9; i++) begin : g_db
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk(clk),
            .rst(rst),
            .raw(raw[i]),
            .db (db[i])
        );
    end

    // Scan from b down to c so the lowest pitch wins.
    always_comb begin
        code_nxt = NOTE_NONE;
        for (int k = 6; k >= 0; k--) begin
            if (db[k])
                code_nxt = 3'(k + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q   <= NOTE_NONE;
            onehot_q <= 7'd0;
        end else begin
`ifdef NOTE_KEY_HOLD_EN
            if (code_nxt != NOTE_NONE) begin
                code_q   <= code_nxt;
                onehot_q <= code_onehot(code_nxt);
            end
`else
            code_q   <= code_nxt;
            onehot_q <= code_onehot(code_nxt);
`endif
        end
    end

    assign {b, a, g, f, e, d, c} = onehot_q;
    assign note_code  = code_q;
    assign note_valid = (code_q != NOTE_NONE);

    assign up_e = db[7] & ~btn_q[0];
    assign dn_e = db[8] & ~btn_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            oct   <= MID;
            btn_q <= 2'b00;
        end else begin
            btn_q <= db[8:7];
            if (up_e && !dn_e)
                oct <= (oct == LOW) ? MID : HIGH;
            else if (dn_e && !up_e)
                oct <= (oct == HIGH) ? MID : LOW;
        end
    end

    assign up   = (oct == HIGH);
    assign down = (oct == LOW);

endmodule

// File: tb/tb_note_key_encoder.sv
// Bench for note_key_encoder: directed cases plus random keys vs a model.
// Build with NOTE_KEY_HOLD_EN defined to check the hold variant.
module tb_note_key_encoder;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_c = 0, key_d = 0, key_e = 0, key_f = 0;
    logic       key_g = 0, key_a = 0, key_b = 0;
    logic       btn_up = 0, btn_down = 0;
    logic       c, d, e, f, g, a, b, up, down, note_valid;
    logic [2:0] note_code;

    int vectors = 0;
    int errors  = 0;

    note_key_encoder #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .rst(rst),
        .key_c(key_c), .key_d(key_d), .key_e(key_e), .key_f(key_f),
        .key_g(key_g), .key_a(key_a), .key_b(key_b),
        .btn_up(btn_up), .btn_down(btn_down),
        .c(c), .d(d), .e(e), .f(f), .g(g), .a(a), .b(b),
        .up(up), .down(down),
        .note_valid(note_valid), .note_code(note_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: a key's debounced level flips once the last N
    // samples seen two cycles late all disagree with it.
    bit       mvalid = 0;
    bit       p1 [9];
    bit       p2 [9];
    bit       dbm [9];
    bit       dbp [9];
    int       since [9];
    bit [31:0] hw [9];
    int       oct;
    int       ecode;

    wire [8:0] raw_v = {btn_down, btn_up, key_b, key_a,
                        key_g, key_f, key_e, key_d, key_c};

    always @(posedge clk) begin
        int  code;
        bit  ue, de, v;
        bit [31:0] want;
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                p1[i] = 0; p2[i] = 0; dbm[i] = 0; dbp[i] = 0;
                since[i] = 0; hw[i] = 0;
            end
            oct = 1;
            ecode = 0;
            mvalid = 1;
        end else if (mvalid) begin
            code = 0;
            for (int k = 0; k < 7; k++)
                if (dbm[k] && code == 0) code = k + 1;
`ifdef NOTE_KEY_HOLD_EN
            if (code != 0) ecode = code;
`else
            ecode = code;
`endif
            ue = dbm[7] && !dbp[7];
            de = dbm[8] && !dbp[8];
            if (ue && !de && oct < 2) oct++;
            if (de && !ue && oct > 0) oct--;
            for (int i = 0; i < 9; i++) begin
                dbp[i] = dbm[i];
                v = p2[i];
                p2[i] = p1[i];
                p1[i] = raw_v[i];
                hw[i] = {hw[i][30:0], v};
                since[i]++;
                want = dbm[i] ? 32'd0 : 32'hFFFF_FFFF;
                if (since[i] >= N && hw[i][N-1:0] == want[N-1:0])
                    dbm[i] = !dbm[i];
            end
        end
    end

    always @(negedge clk) begin
        logic [6:0] en;
        if (mvalid) begin
            en = (ecode == 0) ? 7'd0 : 7'(7'd1 << (ecode - 1));
            chk("notes", 32'({b, a, g, f, e, d, c}), 32'(en));
            chk("note_code", 32'(note_code), 32'(ecode));
            chk("note_valid", 32'(note_valid), 32'(ecode != 0));
            chk("octave", 32'({up, down}),
                32'({oct == 2, oct == 0}));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply(input logic [8:0] v);
        {btn_down, btn_up, key_b, key_a,
         key_g, key_f, key_e, key_d, key_c} = v;
    endtask

    task automatic do_reset();
        apply(9'd0);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(12);
    endtask

    int tmr [9];
    logic [8:0] lvl;

    initial begin
        cyc(3);
        rst = 1'b0;
        chk("reset_notes", 32'({b, a, g, f, e, d, c, note_valid}), 32'd0);
        chk("reset_code", 32'(note_code), 32'd0);
        chk("reset_oct", 32'({up, down}), 32'd0);

        // Clean press of e
        do_reset();
        key_e = 1;
        cyc(6);
        chk("press_e_early", 32'(e), 32'd0);
        cyc(1);
        chk("press_e", 32'({e, note_valid}), 32'b11);
        chk("press_e_code", 32'(note_code), 32'd3);

        // Bouncing d
        do_reset();
        for (int t = 0; t < 10; t++) begin
            key_d = ~t[0];
            cyc(2);
            chk("bounce_d_quiet", 32'(d), 32'd0);
        end
        key_d = 1;
        cyc(6);
        chk("bounce_d_early", 32'(d), 32'd0);
        cyc(1);
        chk("bounce_d", 32'({d, note_code}), 32'({1'b1, 3'd2}));

        // Priority c over g
        do_reset();
        key_g = 1;
        key_c = 1;
        cyc(8);
        chk("prio_cg", 32'({c, g, note_code}), 32'({2'b10, 3'd1}));
        key_c = 0;
        cyc(8);
        chk("prio_g", 32'({c, g, note_code}), 32'({2'b01, 3'd5}));

        // Octave walk
        do_reset();
        for (int p = 0; p < 3; p++) begin
            btn_up = 1; cyc(8);
            chk("oct_up", 32'({up, down}), 32'b10);
            btn_up = 0; cyc(8);
        end
        btn_down = 1; cyc(8);
        chk("oct_dn1", 32'({up, down}), 32'b00);
        btn_down = 0; cyc(8);
        btn_down = 1; cyc(8);
        chk("oct_dn2", 32'({up, down}), 32'b01);
        btn_down = 0; cyc(8);

        // Simultaneous up and down cancel
        do_reset();
        btn_up = 1;
        btn_down = 1;
        cyc(10);
        chk("oct_cancel", 32'({up, down}), 32'b00);

        // Reset in the middle of a debounce
        do_reset();
        key_a = 1;
        cyc(2);
        rst = 1; cyc(1); rst = 0;
        cyc(6);
        chk("rst_mid_early", 32'(a), 32'd0);
        cyc(1);
        chk("rst_mid_a", 32'({a, note_code}), 32'({1'b1, 3'd6}));
        key_a = 0;
        cyc(10);
`ifdef NOTE_KEY_HOLD_EN
        chk("release_a", 32'({a, note_valid}), 32'b11);
`else
        chk("release_a", 32'({a, note_valid}), 32'b00);
`endif

        // Random keys with occasional bounce bursts and resets
        do_reset();
        lvl = 9'd0;
        for (int i = 0; i < 9; i++) tmr[i] = 0;
        for (int t = 0; t < 5000; t++) begin
            for (int i = 0; i < 9; i++) begin
                if (tmr[i] == 0) begin
                    lvl[i] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0)
                        tmr[i] = $urandom_range(1, 3);
                    else
                        tmr[i] = $urandom_range(5, 30);
                end else begin
                    tmr[i]--;
                end
            end
            apply(lvl);
            rst = ($urandom_range(0, 799) == 0);
            cyc(1);
        end
        rst = 1'b0;
        apply(9'd0);
        cyc(12);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
